// File: rtl/axi_burst_sram_if.sv
// axi_burst_sram_if: AXI4-style read/write channel bundle for axi_burst_sram.
// Modports: slave (memory side) and master (initiator side).
// Channels: AR, R, AW, W, B with valid/ready handshakes.
interface axi_burst_sram_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic              ar_valid, ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              r_valid, r_ready;
    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              aw_valid, aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [ID_W-1:0]   aw_id;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic                w_valid, w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic              b_valid, b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    modport slave (
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  w_valid, w_data, w_strb, w_last, b_ready,
        output ar_ready, r_valid, r_data, r_id, r_resp, r_last,
        output aw_ready, w_ready, b_valid, b_id, b_resp
    );
    modport master (
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output w_valid, w_data, w_strb, w_last, b_ready,
        input  ar_ready, r_valid, r_data, r_id, r_resp, r_last,
        input  aw_ready, w_ready, b_valid, b_id, b_resp
    );
endinterface

// File: rtl/axi_burst_sram.sv
// axi_burst_sram: burst-capable AXI-style SRAM with independent read and write FSMs.
// Ports: clock, reset (synchronous, active-low), bus (axi_burst_sram_if.slave).
// Define AXI_BURST_SRAM_WRAP_EN to support WRAP bursts; otherwise WRAP behaves as INCR.
module axi_burst_sram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ID_W   = 4
) (
    input logic clock,
    input logic reset,
    axi_burst_sram_if.slave bus
);
    localparam int LB = $clog2(DATA_W/8);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RIDLE, RDATA} rstate_t;
    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;

    logic [DATA_W-1:0] mem [DEPTH];
    rstate_t r_state;
    wstate_t w_state;
    logic [ADDR_W-1:0] r_addr, w_addr, r_next, w_next, r_idx, w_idx;
    logic [7:0] r_len, r_cnt, w_len, w_cnt;
    logic [2:0] r_size, w_size;
    logic [1:0] r_burst, w_burst;
    logic r_ok, w_ok, w_err, w_fire, w_bad;

    // Beats wider than the bus are treated as full-width beats.
    function automatic logic [2:0] eff(input logic [2:0] size);
        return size > 3'(LB) ? 3'(LB) : size;
    endfunction

    function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        step = ADDR_W'(1) << eff(size);
        return burst == 2'b00 ? a : (a & ~(step - 1'b1)) + step;
    endfunction

`ifdef AXI_BURST_SRAM_WRAP_EN
    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                               input logic [7:0] len);
        logic [ADDR_W-1:0] win;
        win = ADDR_W'({1'b0, len} + 9'd1) << eff(size);
        return (a & ~(win - 1'b1)) | (adv(a, size, 2'b01) & (win - 1'b1));
    endfunction
`endif

    always_comb begin
        r_idx = r_addr >> LB;
        w_idx = w_addr >> LB;
        r_ok = r_idx < ADDR_W'(DEPTH);
        w_ok = w_idx < ADDR_W'(DEPTH);
        r_next = adv(r_addr, r_size, r_burst);
        w_next = adv(w_addr, w_size, w_burst);
`ifdef AXI_BURST_SRAM_WRAP_EN
        if (r_burst == 2'b10 && r_len inside {8'd1, 8'd3, 8'd7, 8'd15}) r_next = wrap(r_addr, r_size, r_len);
        if (w_burst == 2'b10 && w_len inside {8'd1, 8'd3, 8'd7, 8'd15}) w_next = wrap(w_addr, w_size, w_len);
`endif
        // Combinational read of the array sees the value before any same-edge write.
        bus.r_data = r_ok ? mem[r_idx[AW-1:0]] : '0;
        bus.r_resp = bus.r_valid && !r_ok ? 2'b10 : 2'b00;
        w_fire = bus.w_valid && bus.w_ready;
        w_bad = !w_ok || (bus.w_last != (w_cnt == w_len));
    end

    // Memory has no reset so contents survive it; a beat coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (reset && w_fire && w_ok)
            for (int b = 0; b < DATA_W/8; b++)
                if (bus.w_strb[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= bus.w_data[8*b +: 8];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= RIDLE;
            bus.ar_ready <= 1'b1;
            bus.r_valid <= 1'b0;
            bus.r_last <= 1'b0;
            bus.r_id <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_size <= '0;
            r_burst <= '0;
        end else case (r_state)
            RIDLE: if (bus.ar_valid) begin
                r_addr <= bus.ar_addr;
                bus.r_id <= bus.ar_id;
                r_len <= bus.ar_len;
                r_size <= bus.ar_size;
                r_burst <= bus.ar_burst;
                r_cnt <= '0;
                r_state <= RDATA;
                bus.ar_ready <= 1'b0;
                bus.r_valid <= 1'b1;
                bus.r_last <= bus.ar_len == 8'd0;
            end
            RDATA: if (bus.r_ready) begin
                r_cnt <= r_cnt + 8'd1;
                r_addr <= r_next;
                if (bus.r_last) begin
                    r_state <= RIDLE;
                    bus.ar_ready <= 1'b1;
                    bus.r_valid <= 1'b0;
                    bus.r_last <= 1'b0;
                end else bus.r_last <= r_cnt + 8'd1 == r_len;
            end
        endcase
    end

    // The error flag is sticky for the life of a burst and reported once in B.
    always_ff @(posedge clock) begin
        if (!reset) begin
            w_state <= WIDLE;
            bus.aw_ready <= 1'b1;
            bus.w_ready <= 1'b0;
            bus.b_valid <= 1'b0;
            bus.b_id <= '0;
            bus.b_resp <= 2'b00;
            w_addr <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_size <= '0;
            w_burst <= '0;
            w_err <= 1'b0;
        end else case (w_state)
            WIDLE: if (bus.aw_valid) begin
                w_addr <= bus.aw_addr;
                bus.b_id <= bus.aw_id;
                w_len <= bus.aw_len;
                w_size <= bus.aw_size;
                w_burst <= bus.aw_burst;
                w_cnt <= '0;
                w_err <= 1'b0;
                w_state <= WDATA;
                bus.aw_ready <= 1'b0;
                bus.w_ready <= 1'b1;
            end
            WDATA: if (bus.w_valid) begin
                w_cnt <= w_cnt + 8'd1;
                w_addr <= w_next;
                if (w_bad) w_err <= 1'b1;
                if (w_cnt == w_len) begin
                    w_state <= WRESP;
                    bus.w_ready <= 1'b0;
                    bus.b_valid <= 1'b1;
                    bus.b_resp <= w_err || w_bad ? 2'b10 : 2'b00;
                end
            end
            WRESP: if (bus.b_ready) begin
                w_state <= WIDLE;
                bus.b_valid <= 1'b0;
                bus.aw_ready <= 1'b1;
                bus.b_resp <= 2'b00;
            end
            default: begin
                w_state <= WIDLE;
                bus.aw_ready <= 1'b1;
                bus.w_ready <= 1'b0;
                bus.b_valid <= 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_axi_burst_sram.sv
// tb_axi_burst_sram: directed self-checking bench for axi_burst_sram.
module tb_axi_burst_sram;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_rid;

    always #5 clock = ~clock;

    axi_burst_sram_if #(.DATA_W(64), .ADDR_W(32), .ID_W(4)) bus ();

    axi_burst_sram #(.DATA_W(64), .ADDR_W(32), .DEPTH(4096), .ID_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.aw_valid = 1'b1;
        bus.aw_addr = addr;
        bus.aw_id = id;
        bus.aw_len = len;
        bus.aw_size = size;
        bus.aw_burst = burst;
        for (int i = 0; i < 50 && !bus.aw_ready; i++) step();
        check("aw_ready", bus.aw_ready, 1);
        step();
        bus.aw_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bus.w_valid = 1'b1;
        bus.w_data = data;
        bus.w_strb = strb;
        bus.w_last = last;
        for (int i = 0; i < 50 && !bus.w_ready; i++) step();
        check("w_ready", bus.w_ready, 1);
        step();
        bus.w_valid = 1'b0;
    endtask

    task automatic b_wait(input string tag, input logic [3:0] id, input logic [1:0] resp);
        bus.b_ready = 1'b1;
        for (int i = 0; i < 50 && !bus.b_valid; i++) step();
        check({tag, "_b_valid"}, bus.b_valid, 1);
        check({tag, "_b_resp"}, bus.b_resp, resp);
        check({tag, "_b_id"}, bus.b_id, id);
        step();
        bus.b_ready = 1'b0;
    endtask

    task automatic ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.ar_valid = 1'b1;
        bus.ar_addr = addr;
        bus.ar_id = id;
        bus.ar_len = len;
        bus.ar_size = size;
        bus.ar_burst = burst;
        exp_rid = id;
        for (int i = 0; i < 50 && !bus.ar_ready; i++) step();
        check("ar_ready", bus.ar_ready, 1);
        step();
        bus.ar_valid = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [63:0] data, input logic [1:0] resp, input logic last);
        bus.r_ready = 1'b1;
        for (int i = 0; i < 50 && !bus.r_valid; i++) step();
        check({tag, "_r_valid"}, bus.r_valid, 1);
        check({tag, "_r_data"}, bus.r_data, data);
        check({tag, "_r_resp"}, bus.r_resp, resp);
        check({tag, "_r_last"}, bus.r_last, last);
        check({tag, "_r_id"}, bus.r_id, exp_rid);
        step();
        bus.r_ready = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_ar_ready"}, bus.ar_ready, 1);
        check({tag, "_aw_ready"}, bus.aw_ready, 1);
        check({tag, "_r_valid"}, bus.r_valid, 0);
        check({tag, "_w_ready"}, bus.w_ready, 0);
        check({tag, "_b_valid"}, bus.b_valid, 0);
        check({tag, "_r_last"}, bus.r_last, 0);
        check({tag, "_r_resp"}, bus.r_resp, 0);
        check({tag, "_b_resp"}, bus.b_resp, 0);
    endtask

    initial begin
        logic [63:0] wexp [4];
        bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_id = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_id = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
        bus.r_ready = 0; bus.b_ready = 0;
        step();
        step();
        reset = 1'b1;
        idle_outputs("reset");

        // INCR write then read-back of the same four-beat burst
        aw(32'h100, 4'd5, 8'd3, 3'd3, 2'b01);
        for (int i = 1; i <= 4; i++) w_beat(64'(i), 8'hFF, i == 4);
        b_wait("incr_wr", 4'd5, 2'b00);
        ar(32'h100, 4'd6, 8'd3, 3'd3, 2'b01);
        check("first_beat_latency", bus.r_valid, 1);
        for (int i = 1; i <= 4; i++) r_beat("incr_rd", 64'(i), 2'b00, i == 4);

        // Narrow byte write merges into an existing word
        aw(32'h0, 4'd1, 8'd0, 3'd3, 2'b01);
        w_beat(64'h11223344_55667788, 8'hFF, 1'b1);
        b_wait("full_wr", 4'd1, 2'b00);
        aw(32'h3, 4'd2, 8'd0, 3'd0, 2'b01);
        w_beat(64'h00000000_AA000000, 8'h08, 1'b1);
        b_wait("byte_wr", 4'd2, 2'b00);
        ar(32'h0, 4'd2, 8'd0, 3'd3, 2'b01);
        r_beat("byte_rd", 64'h11223344_AA667788, 2'b00, 1'b1);

        // Fill 0x120..0x130 so WRAP and INCR readings of 0x118 differ
        aw(32'h120, 4'd7, 8'd2, 3'd3, 2'b01);
        for (int i = 5; i <= 7; i++) w_beat(64'(i), 8'hFF, i == 7);
        b_wait("fill_wr", 4'd7, 2'b00);
`ifdef AXI_BURST_SRAM_WRAP_EN
        wexp = '{64'd4, 64'd1, 64'd2, 64'd3};
`else
        wexp = '{64'd4, 64'd5, 64'd6, 64'd7};
`endif
        ar(32'h118, 4'd8, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) r_beat("wrap_rd", wexp[i], 2'b00, i == 3);

        // FIXED, narrow (size 2) and oversize (size 7) reads
        ar(32'h108, 4'd9, 8'd1, 3'd3, 2'b00);
        r_beat("fixed_rd0", 64'd2, 2'b00, 1'b0);
        r_beat("fixed_rd1", 64'd2, 2'b00, 1'b1);
        ar(32'h100, 4'd10, 8'd1, 3'd2, 2'b01);
        r_beat("narrow_rd0", 64'd1, 2'b00, 1'b0);
        r_beat("narrow_rd1", 64'd1, 2'b00, 1'b1);
        ar(32'h100, 4'd11, 8'd1, 3'd7, 2'b01);
        r_beat("wide_rd0", 64'd1, 2'b00, 1'b0);
        r_beat("wide_rd1", 64'd2, 2'b00, 1'b1);

        // Early w_last flags an error but the beat count still ends the burst
        aw(32'h140, 4'd12, 8'd1, 3'd3, 2'b01);
        w_beat(64'h55, 8'hFF, 1'b1);
        w_beat(64'h66, 8'hFF, 1'b1);
        b_wait("wlast_err", 4'd12, 2'b10);
        ar(32'h140, 4'd12, 8'd1, 3'd3, 2'b01);
        r_beat("wlast_rd0", 64'h55, 2'b00, 1'b0);
        r_beat("wlast_rd1", 64'h66, 2'b00, 1'b1);

        // Burst running off the end of memory
        aw(32'h7FF8, 4'd3, 8'd1, 3'd3, 2'b01);
        w_beat(64'hDEAD, 8'hFF, 1'b0);
        w_beat(64'hBEEF, 8'hFF, 1'b1);
        b_wait("oob_wr", 4'd3, 2'b10);
        ar(32'h7FF8, 4'd4, 8'd1, 3'd3, 2'b01);
        r_beat("oob_rd0", 64'hDEAD, 2'b00, 1'b0);
        r_beat("oob_rd1", 64'h0, 2'b10, 1'b1);

        // Stall mid-burst: data must hold while r_ready is low
        ar(32'h100, 4'd13, 8'd3, 3'd3, 2'b01);
        r_beat("stall_rd", 64'd1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", bus.r_valid, 1);
            check("stall_data", bus.r_data, 64'd2);
            step();
        end
        for (int i = 2; i <= 4; i++) r_beat("stall_rd", 64'(i), 2'b00, i == 4);

        // Reset during beat 2 of a write aborts it and leaves memory intact
        aw(32'h200, 4'd14, 8'd3, 3'd3, 2'b01);
        w_beat(64'h1234, 8'hFF, 1'b0);
        bus.w_valid = 1'b1;
        bus.w_data = 64'h5678;
        bus.w_strb = 8'hFF;
        bus.w_last = 1'b0;
        reset = 1'b0;
        step();
        bus.w_valid = 1'b0;
        reset = 1'b1;
        idle_outputs("mid_reset");
        ar(32'h100, 4'd15, 8'd0, 3'd3, 2'b01);
        r_beat("keep_rd0", 64'd1, 2'b00, 1'b1);
        ar(32'h200, 4'd15, 8'd0, 3'd3, 2'b01);
        r_beat("keep_rd1", 64'h1234, 2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
